cmd_out_writer: RTL and testbench

Receives task-finished notifications from accelerators over an AXI-Stream and writes them as 4-word entries into the per-accelerator command-out queue BRAM that the host polls. It is the return path of the command dispatch: once an entry is committed, it pulses the accelerator-availability write port consumed by the command-in dispatcher, freeing that accelerator for its next task.

---
 rtl/cmd_out_writer.sv | 177 +++++++++++++++++
 tb/tb_cmd_out_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_out_writer.sv
// rtl/cmd_out_writer.sv - writes accelerator task-finished messages as 4-word command-out queue entries
// Header goes last so the host never sees a valid entry with stale payload; the accelerator is then released.
module cmd_out_writer #(
  parameter int  MAX_ACCS      = 16,
  parameter int  SUBQUEUE_BITS = 6,
  localparam int ACC_BITS      = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         inStream_TDATA,
  input  logic                inStream_TVALID,
  output logic                inStream_TREADY,
  input  logic [ACC_BITS-1:0] inStream_TID,
  input  logic                inStream_TLAST,
  output logic [31:0]         cmdOutQueue_addr,
  output logic                cmdOutQueue_en,
  output logic [7:0]          cmdOutQueue_we,
  output logic [63:0]         cmdOutQueue_din,
  input  logic [63:0]         cmdOutQueue_dout,
  output logic                cmdOutQueue_clk,
  output logic [ACC_BITS-1:0] acc_avail_wr_address,
  output logic                acc_avail_wr
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_READ_HDR   = 4'd1;
  localparam logic [3:0] S_CHECK_HDR  = 4'd2;
  localparam logic [3:0] S_RECV_TID   = 4'd3;
  localparam logic [3:0] S_RECV_PID   = 4'd4;
  localparam logic [3:0] S_DRAIN      = 4'd5;
  localparam logic [3:0] S_WRITE_PID0 = 4'd6;
  localparam logic [3:0] S_WRITE_TS   = 4'd7;
  localparam logic [3:0] S_WRITE_HDR  = 4'd8;

  logic [3:0]               state_q, state_d;
  logic [ACC_BITS-1:0]      acc_id_q, acc_id_d;
  logic [SUBQUEUE_BITS-1:0] idx_q, idx_d;
  logic [63:0]              ts_q, ts_d;
  logic [63:0]              ts_lat_q, ts_lat_d;
  logic                     avail_wr_q, avail_wr_d;
  logic [ACC_BITS-1:0]      avail_addr_q, avail_addr_d;
  logic [SUBQUEUE_BITS-1:0] wr_idx_q [MAX_ACCS];
  logic [SUBQUEUE_BITS-1:0] wr_idx_d [MAX_ACCS];
  logic [SUBQUEUE_BITS-1:0] word_idx;
  logic                     unused_dout;

  assign unused_dout          = ^cmdOutQueue_dout[62:0];
  assign cmdOutQueue_clk      = clk;
  assign cmdOutQueue_addr     = 32'({acc_id_q, word_idx, 3'b000});
  assign acc_avail_wr         = avail_wr_q;
  assign acc_avail_wr_address = avail_addr_q;

  always_comb begin
    state_d         = state_q;
    acc_id_d        = acc_id_q;
    idx_d           = idx_q;
    ts_d            = ts_q + 64'd1;
    ts_lat_d        = ts_lat_q;
    avail_wr_d      = 1'b0;
    avail_addr_d    = avail_addr_q;
    wr_idx_d        = wr_idx_q;
    word_idx        = idx_q;
    inStream_TREADY = 1'b0;
    cmdOutQueue_en  = 1'b0;
    cmdOutQueue_we  = 8'h00;
    cmdOutQueue_din = 64'h0;

    case (state_q)
      S_IDLE: begin
        if (inStream_TVALID) begin
          acc_id_d = inStream_TID;
          idx_d    = wr_idx_q[inStream_TID];
          state_d  = S_READ_HDR;
        end
      end
      S_READ_HDR: begin
        cmdOutQueue_en = 1'b1;
        state_d        = S_CHECK_HDR;
      end
      // A still-valid header means the host has not consumed this slot yet: keep polling.
      S_CHECK_HDR: begin
        state_d = cmdOutQueue_dout[63] ? S_READ_HDR : S_RECV_TID;
      end
      S_RECV_TID: begin
        inStream_TREADY = 1'b1;
        word_idx        = idx_q + SUBQUEUE_BITS'(1);
        if (inStream_TVALID) begin
          cmdOutQueue_en  = 1'b1;
          cmdOutQueue_we  = 8'hFF;
          cmdOutQueue_din = inStream_TDATA;
          if (inStream_TLAST) begin
            ts_lat_d = ts_q;
            state_d  = S_WRITE_PID0;
          end else begin
            state_d  = S_RECV_PID;
          end
        end
      end
      S_RECV_PID: begin
        inStream_TREADY = 1'b1;
        word_idx        = idx_q + SUBQUEUE_BITS'(2);
        if (inStream_TVALID) begin
          cmdOutQueue_en  = 1'b1;
          cmdOutQueue_we  = 8'hFF;
          cmdOutQueue_din = inStream_TDATA;
          if (inStream_TLAST) begin
            ts_lat_d = ts_q;
            state_d  = S_WRITE_TS;
          end else begin
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        inStream_TREADY = 1'b1;
        if (inStream_TVALID && inStream_TLAST) begin
          ts_lat_d = ts_q;
          state_d  = S_WRITE_TS;
        end
      end
      S_WRITE_PID0: begin
        word_idx       = idx_q + SUBQUEUE_BITS'(2);
        cmdOutQueue_en = 1'b1;
        cmdOutQueue_we = 8'hFF;
        state_d        = S_WRITE_TS;
      end
      S_WRITE_TS: begin
        word_idx        = idx_q + SUBQUEUE_BITS'(3);
        cmdOutQueue_en  = 1'b1;
        cmdOutQueue_we  = 8'hFF;
        cmdOutQueue_din = ts_lat_q;
        state_d         = S_WRITE_HDR;
      end
      S_WRITE_HDR: begin
        cmdOutQueue_en     = 1'b1;
        cmdOutQueue_we     = 8'hFF;
        cmdOutQueue_din    = {8'h80, 40'h0, 8'(acc_id_q), 8'h03};
        wr_idx_d[acc_id_q] = idx_q + SUBQUEUE_BITS'(4);
        avail_wr_d         = 1'b1;
        avail_addr_d       = acc_id_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Nothing is acknowledged or written while reset is asserted, so a reset never commits a beat.
    if (rst) begin
      inStream_TREADY = 1'b0;
      cmdOutQueue_en  = 1'b0;
      cmdOutQueue_we  = 8'h00;
      cmdOutQueue_din = 64'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_id_q     <= '0;
      idx_q        <= '0;
      ts_q         <= 64'h0;
      ts_lat_q     <= 64'h0;
      avail_wr_q   <= 1'b0;
      avail_addr_q <= '0;
      for (int i = 0; i < MAX_ACCS; i++) wr_idx_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      acc_id_q     <= acc_id_d;
      idx_q        <= idx_d;
      ts_q         <= ts_d;
      ts_lat_q     <= ts_lat_d;
      avail_wr_q   <= avail_wr_d;
      avail_addr_q <= avail_addr_d;
      wr_idx_q     <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_cmd_out_writer.sv
// tb/tb_cmd_out_writer.sv - directed self-checking bench for cmd_out_writer
// Models the command-out BRAM as a read-first synchronous RAM with a host backdoor.
module tb_cmd_out_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [3:0]  s_tid;
  logic        s_tlast;
  logic [31:0] q_addr;
  logic        q_en;
  logic [7:0]  q_we;
  logic [63:0] q_din;
  logic [63:0] q_dout;
  logic        q_clk;
  logic [3:0]  av_addr;
  logic        av_wr;

  always #5 clk = ~clk;

  cmd_out_writer #(.MAX_ACCS(16), .SUBQUEUE_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .inStream_TDATA(s_tdata), .inStream_TVALID(s_tvalid), .inStream_TREADY(s_tready),
    .inStream_TID(s_tid), .inStream_TLAST(s_tlast),
    .cmdOutQueue_addr(q_addr), .cmdOutQueue_en(q_en), .cmdOutQueue_we(q_we),
    .cmdOutQueue_din(q_din), .cmdOutQueue_dout(q_dout), .cmdOutQueue_clk(q_clk),
    .acc_avail_wr_address(av_addr), .acc_avail_wr(av_wr)
  );

  logic [63:0] mem [0:1023];
  logic [63:0] dout_r = 64'h0;
  logic [63:0] wtmp;
  logic [63:0] cyc = 64'h0;
  logic [9:0]  q_word;
  logic        unused_bits;
  int          wlog[$];
  int          rd_cnt = 0;
  int          rd_other = 0;
  int          rd_watch = 0;
  int          avail_cnt = 0;
  int          passed = 0;
  int          total = 0;

  assign q_word      = q_addr[12:3];
  assign q_dout      = dout_r;
  assign unused_bits = ^{q_addr[31:13], q_addr[2:0], q_clk};

  always @(posedge clk) begin
    if (q_en) begin
      if (q_we != 8'h00) begin
        wtmp = mem[q_word];
        for (int b = 0; b < 8; b++) if (q_we[b]) wtmp[b*8 +: 8] = q_din[b*8 +: 8];
        mem[q_word] = wtmp;
        wlog.push_back(int'(q_word));
      end else begin
        dout_r <= mem[q_word];
        rd_cnt++;
        if (int'(q_word) != rd_watch) rd_other++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 64'h0;
    else     cyc <= cyc + 64'd1;
  end

  always @(negedge clk) if (av_wr) avail_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] a);
    return {8'h80, 40'h0, a, 8'h03};
  endfunction

  logic [63:0] msg [4];
  logic [63:0] start_cyc, first_beat_cyc, last_ts, av_cyc, clr_cyc;
  logic [3:0]  av_seen_addr;
  bit          send_ok, av_seen;

  // Called at a falling edge; drives one message beat by beat, bounded per beat.
  task automatic send_msg(input logic [3:0] tid, input int n);
    int waitc;
    send_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_tdata  = msg[i];
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      s_tid    = (i == 0) ? tid : (tid ^ 4'hF);
      if (i == 0) start_cyc = cyc;
      #1;
      waitc = 0;
      while (!s_tready && waitc < 200) begin
        @(negedge clk); #1; waitc++;
      end
      if (!s_tready) begin
        send_ok = 1'b0;
        break;
      end
      if (i == 0) first_beat_cyc = cyc;
      if (i == n - 1) last_ts = cyc;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_avail();
    av_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (av_wr) begin
        av_seen = 1'b1; av_cyc = cyc; av_seen_addr = av_addr;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          a0, r0;
  bit          all_ok, stall_bad;
  logic [63:0] ts1, ts2, ts3, ts4;
  int          exp_log [4];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    s_tvalid = 1'b0; s_tdata = 64'h0; s_tid = 4'h0; s_tlast = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_en", 64'(q_en), 64'd0);
    check("rst_we", 64'(q_we), 64'd0);
    check("rst_din", q_din, 64'd0);
    check("rst_avail_wr", 64'(av_wr), 64'd0);
    check("rst_avail_addr", 64'(av_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single message to acc 3
    msg[0] = 64'hAAAA; msg[1] = 64'hBBBB;
    wlog.delete();
    a0 = avail_cnt;
    send_msg(4'd3, 2);
    wait_avail();
    check("single_send_ok", 64'(send_ok), 64'd1);
    check("single_avail_seen", 64'(av_seen), 64'd1);
    check("single_avail_latency", av_cyc - start_cyc, 64'd7);
    check("single_avail_addr", 64'(av_seen_addr), 64'd3);
    check("single_w1", mem[10'hC1], 64'hAAAA);
    check("single_w2", mem[10'hC2], 64'hBBBB);
    check("single_ts", mem[10'hC3], last_ts);
    check("single_hdr", mem[10'hC0], 64'h8000_0000_0000_0303);
    exp_log = '{10'hC1, 10'hC2, 10'hC3, 10'hC0};
    check("single_wr_count", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("single_wr_order%0d", i), 64'(wlog[i]), 64'(exp_log[i]));
    repeat (3) @(negedge clk);
    check("single_avail_once", 64'(avail_cnt - a0), 64'd1);

    // Full queue at acc 5 idx 0: stall and poll until the host clears the valid bit
    mem[320] = 64'h8000_0000_0000_0000;
    msg[0] = 64'h5555; msg[1] = 64'h5AAA;
    r0 = rd_cnt; rd_other = 0; rd_watch = 320; stall_bad = 1'b0;
    fork
      send_msg(4'd5, 2);
      begin
        repeat (20) begin
          @(negedge clk); #2;
          if (s_tready) stall_bad = 1'b1;
        end
        mem[320][63] = 1'b0;
        clr_cyc = cyc;
      end
    join
    wait_avail();
    check("full_tready_low", 64'(stall_bad), 64'd0);
    check("full_polls", 64'((rd_cnt - r0) >= 8), 64'd1);
    check("full_poll_addr", 64'(rd_other), 64'd0);
    check("full_release_time", 64'((first_beat_cyc > clr_cyc) && (first_beat_cyc - clr_cyc <= 3)), 64'd1);
    check("full_w1", mem[321], 64'h5555);
    check("full_hdr", mem[320], hdr(8'd5));

    // Wrap: 16 entries fill acc 0, 17th lands back at idx 0, 18th at idx 4
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      msg[0] = 64'h1000 + 64'(i); msg[1] = 64'h2000 + 64'(i);
      send_msg(4'd0, 2);
      wait_avail();
      all_ok &= send_ok & av_seen;
    end
    check("wrap_16_ok", 64'(all_ok), 64'd1);
    check("wrap_idx60", mem[61], 64'h100F);
    mem[0][63] = 1'b0;
    msg[0] = 64'h1111; msg[1] = 64'h2222;
    send_msg(4'd0, 2);
    wait_avail();
    check("wrap_17_w1", mem[1], 64'h1111);
    check("wrap_17_w2", mem[2], 64'h2222);
    check("wrap_17_hdr", mem[0], hdr(8'd0));
    mem[4][63] = 1'b0;
    msg[0] = 64'h3333; msg[1] = 64'h4444;
    send_msg(4'd0, 2);
    wait_avail();
    check("wrap_next_idx4", mem[5], 64'h3333);

    // Early TLAST on word0 at acc 6
    mem[386] = 64'hDEAD;
    msg[0] = 64'h6666;
    send_msg(4'd6, 1);
    wait_avail();
    check("early_w1", mem[385], 64'h6666);
    check("early_pid_zero", mem[386], 64'h0);
    check("early_ts", mem[387], last_ts);
    check("early_hdr", mem[384], hdr(8'd6));

    // Four-beat message at acc 7: extra beats dropped
    msg[0] = 64'h7A; msg[1] = 64'h7B; msg[2] = 64'h7C; msg[3] = 64'h7D;
    send_msg(4'd7, 4);
    wait_avail();
    check("long_send_ok", 64'(send_ok), 64'd1);
    check("long_w1", mem[449], 64'h7A);
    check("long_w2", mem[450], 64'h7B);
    check("long_ts_last_beat", mem[451], last_ts);
    check("long_hdr", mem[448], hdr(8'd7));
    check("long_avail_addr", 64'(av_seen_addr), 64'd7);

    // Interleaved accelerators 1 and 2
    msg[1] = 64'h0;
    msg[0] = 64'h11; send_msg(4'd1, 2); wait_avail(); ts1 = last_ts;
    msg[0] = 64'h21; send_msg(4'd2, 2); wait_avail(); ts2 = last_ts;
    msg[0] = 64'h12; send_msg(4'd1, 2); wait_avail(); ts3 = last_ts;
    msg[0] = 64'h22; send_msg(4'd2, 2); wait_avail(); ts4 = last_ts;
    check("ilv_acc1_e0", mem[65], 64'h11);
    check("ilv_acc1_e1", mem[69], 64'h12);
    check("ilv_acc2_e0", mem[129], 64'h21);
    check("ilv_acc2_e1", mem[133], 64'h22);
    check("ilv_acc1_idx8_untouched", mem[72], 64'h0);
    check("ilv_ts_exact", mem[67], ts1);
    check("ilv_ts_exact4", mem[135], ts4);
    check("ilv_ts_increasing", 64'((mem[67] < mem[131]) && (mem[131] < mem[71]) && (mem[71] < mem[135])), 64'd1);
    check("ilv_ts_model", 64'((ts2 == mem[131]) && (ts3 == mem[71])), 64'd1);

    // Reset during RECV_PID at acc 9
    a0 = avail_cnt;
    s_tdata = 64'h9999; s_tid = 4'd9; s_tlast = 1'b0; s_tvalid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !s_tready; i++) begin @(negedge clk); #1; end
    check("rstmid_first_beat", 64'(s_tready), 64'd1);
    @(negedge clk);
    s_tdata = 64'h9AAA; s_tlast = 1'b1;
    #1;
    check("rstmid_in_pid", 64'(s_tready), 64'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmid_tready", 64'(s_tready), 64'd0);
    check("rstmid_en", 64'(q_en), 64'd0);
    check("rstmid_we", 64'(q_we), 64'd0);
    check("rstmid_din", q_din, 64'd0);
    check("rstmid_avail", 64'(av_wr), 64'd0);
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_hdr", mem[576], 64'h0);
    check("rstmid_pid_unwritten", mem[578], 64'h0);
    check("rstmid_no_avail", 64'(avail_cnt - a0), 64'd0);
    msg[0] = 64'h9BBB; msg[1] = 64'h9CCC;
    send_msg(4'd9, 2);
    wait_avail();
    check("rstmid_after_w1", mem[577], 64'h9BBB);
    check("rstmid_after_hdr", mem[576], hdr(8'd9));
    check("rstmid_after_avail", 64'(av_seen_addr), 64'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
